// File: rtl/game_event_queue.sv
// game_event_queue: captures card flip / match / win pulses, encodes each as a byte frame
// and buffers the bytes in a show-ahead FIFO that drains over a valid/ready byte handshake.
// Optional macro EVT_TIMESTAMP_EN appends a captured 8-bit tick byte after every frame.
module game_event_queue #(
  parameter int DEPTH    = 16,
  parameter int AW       = $clog2(DEPTH),
  parameter int TICK_DIV = 100000
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          card_flipped,
  input  logic [3:0]    card_pos,
  input  logic          card_matched,
  input  logic          game_won,
  input  logic [7:0]    move_count,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [AW:0]   fifo_level,
  output logic [7:0]    drop_count
);

`ifdef EVT_TIMESTAMP_EN
  typedef enum logic [2:0] {IDLE, FLIP, MATCH, WIN_HDR, WIN_CNT, TS} state_t;
  localparam state_t FRAME_END = TS;
`else
  typedef enum logic [2:0] {IDLE, FLIP, MATCH, WIN_HDR, WIN_CNT} state_t;
  localparam state_t FRAME_END = IDLE;
`endif

  state_t          state_q;
  logic [7:0]      frame_q;
  logic            flip_pend_q, match_pend_q, win_pend_q;
  logic [3:0]      flip_pos_q;
  logic [7:0]      win_cnt_q;
  logic [7:0]      drop_q, drop_d;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic            wr_vld;
  logic [7:0]      wr_dat;
  logic            full, push, pop;
  logic            flip_clr, match_clr, win_clr;
  logic            flip_drop, match_drop, win_drop;
  logic [1:0]      drop_n;
  logic [8:0]      drop_sum;

  // IDLE hands out pending events by priority flip > match > win
  assign flip_clr  = (state_q == IDLE) && flip_pend_q;
  assign match_clr = (state_q == IDLE) && !flip_pend_q && match_pend_q;
  assign win_clr   = (state_q == IDLE) && !flip_pend_q && !match_pend_q && win_pend_q;

  // A repeat pulse is lost only if the earlier one is not being consumed this cycle
  assign flip_drop  = card_flipped && flip_pend_q  && !flip_clr;
  assign match_drop = card_matched && match_pend_q && !match_clr;
  assign win_drop   = game_won     && win_pend_q   && !win_clr;

  assign drop_n   = 2'(flip_drop) + 2'(match_drop) + 2'(win_drop);
  assign drop_sum = {1'b0, drop_q} + {7'd0, drop_n};
  assign drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

  assign full = (count_q == (AW+1)'(DEPTH));
  assign push = wr_vld && !full;
  assign pop  = tx_valid && tx_ready;

  assign tx_valid   = (count_q != '0);
  assign tx_data    = mem_q[rd_ptr_q];
  assign fifo_level = count_q;
  assign drop_count = drop_q;

`ifdef EVT_TIMESTAMP_EN
  logic [31:0] div_q;
  logic [7:0]  tick_q, flip_ts_q, match_ts_q, win_ts_q, ts_frame_q;

  // Free-running timestamp: one tick every TICK_DIV cycles, wraps at 255
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q  <= '0;
      tick_q <= '0;
    end else if (div_q == 32'(TICK_DIV - 1)) begin
      div_q  <= '0;
      tick_q <= tick_q + 8'd1;
    end else begin
      div_q  <= div_q + 32'd1;
    end
  end

  // Timestamps travel with the payload: captured with the event, latched into the frame in IDLE
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flip_ts_q  <= '0;
      match_ts_q <= '0;
      win_ts_q   <= '0;
      ts_frame_q <= '0;
    end else begin
      if (card_flipped && !flip_drop)  flip_ts_q  <= tick_q;
      if (card_matched && !match_drop) match_ts_q <= tick_q;
      if (game_won && !win_drop)       win_ts_q   <= tick_q;
      if (flip_clr)       ts_frame_q <= flip_ts_q;
      else if (match_clr) ts_frame_q <= match_ts_q;
      else if (win_clr)   ts_frame_q <= win_ts_q;
    end
  end
`else
  logic unused_tick_div;
  assign unused_tick_div = (TICK_DIV > 0);
`endif

  // Pending flags and payloads; a new pulse beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flip_pend_q  <= 1'b0;
      match_pend_q <= 1'b0;
      win_pend_q   <= 1'b0;
      flip_pos_q   <= '0;
      win_cnt_q    <= '0;
      drop_q       <= '0;
    end else begin
      if (card_flipped) begin
        flip_pend_q <= 1'b1;
        if (!flip_drop) flip_pos_q <= card_pos;
      end else if (flip_clr) begin
        flip_pend_q <= 1'b0;
      end
      if (card_matched)   match_pend_q <= 1'b1;
      else if (match_clr) match_pend_q <= 1'b0;
      if (game_won) begin
        win_pend_q <= 1'b1;
        if (!win_drop) win_cnt_q <= move_count;
      end else if (win_clr) begin
        win_pend_q <= 1'b0;
      end
      drop_q <= drop_d;
    end
  end

  // Writer FSM: one frame at a time, each state holds its byte until the FIFO has room
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      frame_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (flip_clr) begin
            frame_q <= {4'h1, flip_pos_q};
            state_q <= FLIP;
          end else if (match_clr) begin
            state_q <= MATCH;
          end else if (win_clr) begin
            frame_q <= win_cnt_q;
            state_q <= WIN_HDR;
          end
        end
        FLIP:    if (push) state_q <= FRAME_END;
        MATCH:   if (push) state_q <= FRAME_END;
        WIN_HDR: if (push) state_q <= WIN_CNT;
        WIN_CNT: if (push) state_q <= FRAME_END;
`ifdef EVT_TIMESTAMP_EN
        TS:      if (push) state_q <= IDLE;
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  // Byte offered by the writer in the current state
  always_comb begin
    wr_vld = 1'b1;
    wr_dat = 8'h00;
    case (state_q)
      FLIP:    wr_dat = frame_q;
      MATCH:   wr_dat = 8'hAA;
      WIN_HDR: wr_dat = 8'hEE;
      WIN_CNT: wr_dat = frame_q;
`ifdef EVT_TIMESTAMP_EN
      TS:      wr_dat = ts_frame_q;
`endif
      default: wr_vld = 1'b0;
    endcase
  end

  // Show-ahead FIFO storage; head byte is read straight from the register array
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wr_dat;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_game_event_queue.sv
// Directed bench for game_event_queue: expected bytes are queued when events are driven
// and compared in order as the DUT hands them to the transmitter.
module tb_game_event_queue;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       card_flipped, card_matched, game_won, tx_ready, tx_valid;
  logic [3:0] card_pos;
  logic [7:0] move_count, tx_data, drop_count;
  logic [4:0] fifo_level;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  game_event_queue dut (
    .clk(clk), .reset_n(reset_n),
    .card_flipped(card_flipped), .card_pos(card_pos),
    .card_matched(card_matched),
    .game_won(game_won), .move_count(move_count),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .fifo_level(fifo_level), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    tx_ready = 1'b1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (exp_q.size() == 0 && !tx_valid) break;
    end
    check({tag, " bytes left"}, exp_q.size(), 0);
    check({tag, " level"}, 32'(fifo_level), 0);
  endtask

  // Scoreboard: every accepted byte must be the oldest outstanding expectation
  always @(negedge clk) begin
    if (reset_n === 1'b1 && tx_valid && tx_ready) begin
      if (exp_q.size() > 0) mon_exp = exp_q.pop_front();
      else                  mon_exp = 8'hxx;
      checks++;
      assert (tx_data === mon_exp) else begin
        errors++;
        $error("FAIL stream byte: observed %0h expected %0h", tx_data, mon_exp);
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; card_flipped = 1'b0; card_pos = '0; card_matched = 1'b0;
    game_won = 1'b0; move_count = '0; tx_ready = 1'b0;
    repeat (3) step();
    check("rst tx_data", 32'(tx_data), 0);
    check("rst tx_valid", 32'(tx_valid), 0);
    check("rst level", 32'(fifo_level), 0);
    check("rst drops", 32'(drop_count), 0);
    reset_n = 1'b1;
    step();

    // Single flip: latency to tx_valid is three cycles
    tx_ready = 1'b1;
    card_flipped = 1'b1; card_pos = 4'h5; exp_q.push_back(8'h15);
    step(); card_flipped = 1'b0;
    check("flip valid N+1", 32'(tx_valid), 0);
    step();
    check("flip valid N+2", 32'(tx_valid), 0);
    step();
    check("flip valid N+3", 32'(tx_valid), 1);
    check("flip data N+3", 32'(tx_data), 32'h15);
    step();
    check("flip level after pop", 32'(fifo_level), 0);

    // Win frame held back, then popped on consecutive cycles
    tx_ready = 1'b0;
    game_won = 1'b1; move_count = 8'd23;
    exp_q.push_back(8'hEE); exp_q.push_back(8'h17);
    step(); game_won = 1'b0;
    repeat (5) step();
    check("win level", 32'(fifo_level), 2);
    check("win head", 32'(tx_data), 32'hEE);
    tx_ready = 1'b1;
    step();
    check("win level after 1 pop", 32'(fifo_level), 1);
    check("win head after 1 pop", 32'(tx_data), 32'h17);
    step();
    check("win level after 2 pops", 32'(fifo_level), 0);

    // All three events in one cycle: priority order, no drops
    card_flipped = 1'b1; card_pos = 4'h3; card_matched = 1'b1;
    game_won = 1'b1; move_count = 8'd9;
    exp_q.push_back(8'h13); exp_q.push_back(8'hAA);
    exp_q.push_back(8'hEE); exp_q.push_back(8'h09);
    step(); card_flipped = 1'b0; card_matched = 1'b0; game_won = 1'b0;
    drain("simul", 60);
    check("simul drops", 32'(drop_count), 0);

    // Overflow: 16 fill the FIFO, 17th stalls in the writer, 18th pends, last two drop
    tx_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      card_flipped = 1'b1; card_pos = 4'(k);
      if (k <= 17) exp_q.push_back({4'h1, 4'(k)});
      step(); card_flipped = 1'b0;
      step();
    end
    repeat (4) step();
    check("ovf level", 32'(fifo_level), 16);
    check("ovf head", 32'(tx_data), 32'h10);
    check("ovf drops", 32'(drop_count), 2);
    drain("ovf", 80);

    // Saturation: continuous match pulses against a full FIFO
    tx_ready = 1'b0;
    card_matched = 1'b1;
    repeat (300) step();
    card_matched = 1'b0;
    step();
    check("sat drops", 32'(drop_count), 255);
    check("sat level", 32'(fifo_level), 16);
    for (int k = 0; k < 18; k++) exp_q.push_back(8'hAA);
    drain("sat", 100);

    // Reset in WIN_HDR with five bytes queued
    tx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      card_flipped = 1'b1; card_pos = 4'(k + 8);
      step(); card_flipped = 1'b0;
      step();
    end
    repeat (3) step();
    game_won = 1'b1; move_count = 8'd42;
    step(); game_won = 1'b0;
    step();
    check("pre-reset level", 32'(fifo_level), 5);
    reset_n = 1'b0;
    exp_q.delete();
    step();
    check("mid rst tx_valid", 32'(tx_valid), 0);
    check("mid rst level", 32'(fifo_level), 0);
    check("mid rst drops", 32'(drop_count), 0);
    check("mid rst tx_data", 32'(tx_data), 0);
    reset_n = 1'b1;
    tx_ready = 1'b1;
    repeat (12) step();
    check("post rst tx_valid", 32'(tx_valid), 0);
    check("post rst level", 32'(fifo_level), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
